// File: rtl/reg_file_sb.sv
// Integer register file (2 comb read ports, 1 sync write port, r0 = 0) with a pending-write
// scoreboard and a registered debug tap. Define REGFILE_BYPASS_EN for write-to-read forwarding.
module reg_file_sb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
  parameter int unsigned DBG_REG  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              busy1,
  output logic              busy2,
  output logic [DATA_W-1:0] dbg_q
);

  // One extra bit so the bound compare is exact for any NUM_REGS.
  localparam logic [ADDR_W:0] NumRegsW = NUM_REGS[ADDR_W:0];

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [DATA_W-1:0]   dbg_d;
  logic                wr_en;

  function automatic logic valid_addr(logic [ADDR_W-1:0] a);
    return (a != '0) && ({1'b0, a} < NumRegsW);
  endfunction

  assign wr_en = we && valid_addr(waddr);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[waddr] = wdata;
    regs_d[0] = '0;
    dbg_d = regs_q[DBG_REG];
  end

  // Issue (set) is applied after retire (clear) so a same-cycle collision stays busy.
  always_comb begin
    busy_d = busy_q;
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      if (we && waddr == ADDR_W'(r)) busy_d[r] = 1'b0;
      if (issue_valid && issue_rd == ADDR_W'(r)) busy_d[r] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    busy1  = 1'b0;
    busy2  = 1'b0;
    if (valid_addr(raddr1)) begin
      rdata1 = regs_q[raddr1];
      busy1  = busy_q[raddr1];
    end
    if (valid_addr(raddr2)) begin
      rdata2 = regs_q[raddr2];
      busy2  = busy_q[raddr2];
    end
`ifdef REGFILE_BYPASS_EN
    if (wr_en && waddr == raddr1) begin
      rdata1 = wdata;
      if (!(issue_valid && issue_rd == waddr)) busy1 = 1'b0;
    end
    if (wr_en && waddr == raddr2) begin
      rdata2 = wdata;
      if (!(issue_valid && issue_rd == waddr)) busy2 = 1'b0;
    end
`else
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      busy_q <= '0;
      dbg_q  <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      dbg_q  <= dbg_d;
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb (NUM_REGS=24 so out-of-range addresses are reachable):
// directed vector table, hand-written reset/debug sequences, then random traffic vs. a model.
module tb_reg_file_sb;
  localparam int DW  = 32;
  localparam int NR  = 24;
  localparam int AW  = $clog2(NR);
  localparam int DBG = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          we, issue_valid;
  logic [AW-1:0] waddr, raddr1, raddr2, issue_rd;
  logic [DW-1:0] wdata, rdata1, rdata2, dbg_q;
  logic          busy1, busy2;

  reg_file_sb #(.DATA_W(DW), .NUM_REGS(NR), .DBG_REG(DBG)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .busy1(busy1), .busy2(busy2),
    .dbg_q(dbg_q)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: architectural state as plain arrays.
  logic [DW-1:0] m_mem [NR];
  bit            m_busy[NR];
  logic [DW-1:0] m_dbg;

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic          iv;
    logic [AW-1:0] ird;
    logic [DW-1:0] r1;
    logic [DW-1:0] r2;
    logic          b1;
    logic          b2;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [DW-1:0] model_rd(input int a);
    if (a == 0 || a >= NR) return '0;
`ifdef REGFILE_BYPASS_EN
    if (we && int'(waddr) == a) return wdata;
`endif
    return m_mem[a];
  endfunction

  function automatic logic model_busy(input int a);
    if (a == 0 || a >= NR) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (we && int'(waddr) == a && !(issue_valid && int'(issue_rd) == a)) return 1'b0;
`endif
    return m_busy[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
    m_dbg = '0;
  endtask

  task automatic model_edge();
    m_dbg = m_mem[DBG];
    for (int r = 1; r < NR; r++) begin
      if (issue_valid && int'(issue_rd) == r) m_busy[r] = 1'b1;
      else if (we && int'(waddr) == r) m_busy[r] = 1'b0;
    end
    if (we && waddr != 0 && int'(waddr) < NR) m_mem[waddr] = wdata;
  endtask

  task automatic drive(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                       input logic iv, input logic [AW-1:0] ird);
    we = w; waddr = wa; wdata = wd; raddr1 = r1; raddr2 = r2; issue_valid = iv; issue_rd = ird;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".rdata1"}, rdata1, model_rd(int'(raddr1)));
    chk({tag, ".rdata2"}, rdata2, model_rd(int'(raddr2)));
    chk({tag, ".busy1"}, DW'(busy1), DW'(model_busy(int'(raddr1))));
    chk({tag, ".busy2"}, DW'(busy2), DW'(model_busy(int'(raddr2))));
    chk({tag, ".dbg_q"}, dbg_q, m_dbg);
  endtask

  // Called at negedge+1; returns at the following negedge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    // Expected outputs are sampled before the edge that applies the row's inputs.
    tbl[0]  = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd0,  1'b1, 5'd0,  '0, '0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 5'd0,  32'h0,         5'd0,  5'd0,  1'b0, 5'd0,  '0, '0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 5'd3,  32'hA5A5_A5A5, 5'd3,  5'd3,  1'b0, 5'd0,  '0, '0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 5'd0,  32'h0,         5'd3,  5'd3,  1'b0, 5'd0,
                32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 5'd0,  32'h0,         5'd4,  5'd3,  1'b1, 5'd4,  '0, 32'hA5A5_A5A5, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 5'd0,  32'h0,         5'd4,  5'd3,  1'b0, 5'd0,  '0, 32'hA5A5_A5A5, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 5'd4,  32'h7,         5'd4,  5'd0,  1'b1, 5'd4,  '0, '0, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 5'd4,  32'h8,         5'd4,  5'd0,  1'b0, 5'd0,  32'h7, '0, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 5'd0,  32'h0,         5'd4,  5'd0,  1'b0, 5'd0,  32'h8, '0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 5'd30, 32'hDEAD_BEEF, 5'd6,  5'd30, 1'b1, 5'd30, '0, '0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 5'd0,  32'h0,         5'd6,  5'd30, 1'b0, 5'd0,  '0, '0, 1'b0, 1'b0};

    rst = 1'b1;
    drive(1'b0, '0, '0, '0, '0, 1'b0, '0);
    model_reset();
    @(negedge clk);
    check_model("reset");
    rst = 1'b0;

    // Mid-run reset must clear data, scoreboard and debug tap without a clock edge.
    drive(1'b1, 5'd5, 32'h1234, 5'd5, 5'd7, 1'b1, 5'd7);
    #1 tick();
    drive(1'b1, 5'd10, 32'h55, 5'd5, 5'd7, 1'b0, 5'd0);
    #1 tick();
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd7, 1'b0, 5'd0);
    #1 tick();
    #1 check_model("pre_rst");
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_async.rdata1", rdata1, 32'h0);
    chk("rst_async.busy2", DW'(busy2), 32'h0);
    chk("rst_async.dbg_q", dbg_q, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ra1, tbl[i].ra2, tbl[i].iv, tbl[i].ird);
      #1;
      chk($sformatf("vec%0d.rdata1", i), rdata1, tbl[i].r1);
      chk($sformatf("vec%0d.rdata2", i), rdata2, tbl[i].r2);
      chk($sformatf("vec%0d.busy1", i), DW'(busy1), DW'(tbl[i].b1));
      chk($sformatf("vec%0d.busy2", i), DW'(busy2), DW'(tbl[i].b2));
      tick();
    end

    // Debug tap: two-edge latency from write to dbg_q.
    drive(1'b1, 5'd10, 32'd42, 5'd10, 5'd0, 1'b0, 5'd0);
    #1 tick();
    drive(1'b0, 5'd0, 32'h0, 5'd10, 5'd0, 1'b0, 5'd0);
    #1 chk("dbg_after_N", dbg_q, 32'h0);
    chk("dbg_reg10_read", rdata1, 32'd42);
    tick();
    #1 chk("dbg_after_N1", dbg_q, 32'd42);

    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), $urandom(),
            AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)));
      // Bias toward the debug register so the tap sees real traffic.
      if ($urandom_range(0, 7) == 0) waddr = AW'(DBG);
      #1 check_model($sformatf("rnd%0d", i));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
